axo_fetch_buffer: RTL and testbench

AXO_FETCH_BUFFER -- requirements
Module: axo_fetch_buffer

---
 rtl/axo_fetch_buffer.sv | 73 +++++++
 tb/tb_axo_fetch_buffer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/axo_fetch_buffer.sv
// axo_fetch_buffer: instruction prefetch FIFO with one outstanding bus request, flush redirect and fault halt
module axo_fetch_buffer #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  input  logic        flush,
  input  logic [31:1] flush_addr,
  output logic        out_valid,
  output logic [31:0] out_insn,
  output logic [31:1] out_pc,
  output logic        out_err,
  input  logic        out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0] mem_insn [DEPTH];
  logic [31:1] mem_pc [DEPTH];
  logic        mem_err [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [31:2] fetch_pc;
  logic [31:0] hold_addr;
  logic drop, halt, live, hold, ack_ok, push, pop;
  logic unused;
  assign unused = flush_addr[1];
  always_comb begin
    bus_req   = rst_n & live & (hold | (count != CW'(DEPTH) & !halt));
    bus_addr  = hold ? hold_addr : {fetch_pc, 2'b00};
    out_valid = rst_n & (count != '0);
    out_insn  = mem_insn[rptr];
    out_pc    = mem_pc[rptr];
    out_err   = mem_err[rptr];
    ack_ok    = bus_req & bus_ack;
    push      = ack_ok & !flush & !drop;
    pop       = out_valid & out_ready & !flush;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      drop     <= 1'b0;
      halt     <= 1'b0;
      live     <= 1'b0;
      hold     <= 1'b0;
      fetch_pc <= RESET_VECTOR[31:2];
    end else begin
      live      <= 1'b1;
      hold      <= bus_req & !bus_ack;
      hold_addr <= bus_addr;
      drop      <= !ack_ok & (drop | (flush & bus_req));
      halt      <= !flush & (halt | (push & bus_err));
      fetch_pc  <= flush ? flush_addr[31:2] : fetch_pc + 30'(push);
      count     <= flush ? '0 : count + CW'(push) - CW'(pop);
      wptr      <= flush ? '0 : wptr + AW'(push);
      rptr      <= flush ? '0 : rptr + AW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_insn[wptr] <= bus_rdata;
      mem_pc[wptr]   <= {fetch_pc, 1'b0};
      mem_err[wptr]  <= bus_err;
    end
  end
endmodule

// File: tb/tb_axo_fetch_buffer.sv
// tb_axo_fetch_buffer: directed vector bench for axo_fetch_buffer
module tb_axo_fetch_buffer;
  localparam logic [31:0] K = 32'hA5C3_0000;
  logic        clk = 1'b0, rst_n = 1'b0, bus_req, bus_ack = 1'b0, bus_err = 1'b0;
  logic        flush = 1'b0, out_valid, out_err, out_ready = 1'b0;
  logic [31:0] bus_addr, bus_rdata = '0, out_insn;
  logic [31:1] flush_addr = '0, out_pc;
  always #5 clk = ~clk;
  axo_fetch_buffer #(.DEPTH(4), .RESET_VECTOR(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .flush(flush), .flush_addr(flush_addr),
    .out_valid(out_valid), .out_insn(out_insn), .out_pc(out_pc), .out_err(out_err),
    .out_ready(out_ready)
  );
  typedef struct {
    logic rst, ack, err, fl;
    logic [31:0] fa;
    logic rdy, ereq;
    logic [31:0] ea;
    logic ev;
    logic [31:0] ep;
    logic ee;
  } vec_t;
  vec_t tv[$];
  int n_vec = 0, n_bad = 0;
  task automatic add(input logic rst, ack, err, fl, input logic [31:0] fa, input logic rdy, ereq,
                     input logic [31:0] ea, input logic ev, input logic [31:0] ep, input logic ee);
    tv.push_back('{rst, ack, err, fl, fa, rdy, ereq, ea, ev, ep, ee});
  endtask
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask
  initial begin
    logic [31:0] fa_t;
    add(0,1,0,0,0,1,            0,0,0,0,0);
    add(0,1,0,0,0,1,            0,0,0,0,0);
    add(1,1,0,0,0,1,            0,0,0,0,0);
    add(1,1,0,0,0,1,            1,'h100,0,0,0);
    add(1,1,0,0,0,1,            1,'h104,1,'h100,0);
    add(1,1,0,0,0,1,            1,'h108,1,'h104,0);
    add(1,0,0,0,0,1,            1,'h10C,1,'h108,0);
    add(1,0,0,1,'h2000,1,       1,'h10C,0,0,0);
    add(1,0,0,0,0,1,            1,'h10C,0,0,0);
    add(1,0,0,0,0,1,            1,'h10C,0,0,0);
    add(1,1,0,0,0,1,            1,'h10C,0,0,0);
    add(1,1,0,0,0,1,            1,'h2000,0,0,0);
    add(1,1,0,0,0,0,            1,'h2004,1,'h2000,0);
    add(1,1,0,1,'h3002,0,       1,'h2008,1,'h2000,0);
    add(1,1,0,0,0,1,            1,'h3000,0,0,0);
    add(1,0,0,1,'h5000,1,       1,'h3004,1,'h3000,0);
    add(1,0,0,1,'h202,1,        1,'h3004,0,0,0);
    add(1,1,1,0,0,1,            1,'h3004,0,0,0);
    add(1,1,1,0,0,0,            1,'h200,0,0,0);
    add(1,1,0,0,0,0,            0,0,1,'h200,1);
    add(1,1,0,0,0,1,            0,0,1,'h200,1);
    add(1,1,0,0,0,1,            0,0,0,0,0);
    add(1,1,0,1,'h400,1,        0,0,0,0,0);
    add(1,1,0,0,0,1,            1,'h400,0,0,0);
    add(1,1,0,0,0,1,            1,'h404,1,'h400,0);
    add(1,1,0,1,'hFFFF_FFFC,1,  1,'h408,1,'h404,0);
    add(1,1,0,0,0,1,            1,'hFFFF_FFFC,0,0,0);
    add(1,1,0,0,0,1,            1,'h0,1,'hFFFF_FFFC,0);
    add(1,1,0,0,0,1,            1,'h4,1,'h0,0);
    add(1,1,0,1,'h600,0,        1,'h8,1,'h4,0);
    add(1,1,0,0,0,0,            1,'h600,0,0,0);
    add(1,1,0,0,0,0,            1,'h604,1,'h600,0);
    add(1,1,0,0,0,0,            1,'h608,1,'h600,0);
    add(1,1,0,0,0,0,            1,'h60C,1,'h600,0);
    add(1,1,0,0,0,0,            0,0,1,'h600,0);
    add(1,1,0,0,0,1,            0,0,1,'h600,0);
    add(1,1,0,0,0,1,            1,'h610,1,'h604,0);
    add(1,1,0,0,0,1,            1,'h614,1,'h608,0);
    add(1,1,0,0,0,1,            1,'h618,1,'h60C,0);
    add(1,1,0,0,0,1,            1,'h61C,1,'h610,0);
    add(0,0,0,0,0,1,            0,0,0,0,0);
    add(1,0,0,0,0,1,            0,0,0,0,0);
    add(1,0,0,0,0,1,            1,'h100,0,0,0);
    add(1,1,0,0,0,1,            1,'h100,0,0,0);
    add(1,0,0,0,0,1,            1,'h104,1,'h100,0);
    foreach (tv[i]) begin
      @(negedge clk);
      rst_n      = tv[i].rst;
      bus_ack    = tv[i].ack;
      bus_err    = tv[i].err;
      flush      = tv[i].fl;
      flush_addr = tv[i].fa[31:1];
      out_ready  = tv[i].rdy;
      bus_rdata  = tv[i].ea ^ K;
      #1;
      n_vec++;
      chk("bus_req", i, 32'(bus_req), 32'(tv[i].ereq));
      if (tv[i].ereq) chk("bus_addr", i, bus_addr, tv[i].ea);
      chk("out_valid", i, 32'(out_valid), 32'(tv[i].ev));
      if (tv[i].ev) begin
        chk("out_pc", i, {out_pc, 1'b0}, tv[i].ep);
        chk("out_insn", i, out_insn, tv[i].ep ^ K);
        chk("out_err", i, 32'(out_err), 32'(tv[i].ee));
      end
    end
    @(negedge clk);
    fa_t       = 32'h800;
    flush      = 1'b1;
    flush_addr = fa_t[31:1];
    bus_ack    = 1'b1;
    bus_err    = 1'b0;
    out_ready  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      flush     = 1'b0;
      bus_rdata = bus_addr ^ K;
      #1;
      n_vec++;
      chk("stream_req", 100 + c, 32'(bus_req), 32'd1);
      chk("stream_addr", 100 + c, bus_addr, 32'h800 + 32'(4 * c));
      chk("stream_valid", 100 + c, 32'(out_valid), 32'(c > 0));
      if (c > 0) begin
        chk("stream_pc", 100 + c, {out_pc, 1'b0}, 32'h800 + 32'(4 * (c - 1)));
        chk("stream_insn", 100 + c, out_insn, (32'h800 + 32'(4 * (c - 1))) ^ K);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
